// File: rtl/uart_rx_stream.sv
// uart_rx_stream: oversampling UART receiver with a valid/ready byte output.
// Frame: start(0), INPUT_DATA_WIDTH data bits LSB first, optional even parity,
// stop(1). Flags parity/framing/overrun problems as one-cycle pulses.
// Optional feature macro: UART_RX_BREAK_DETECT_EN adds break_detected and a
// post-break line-high holdoff before the next start bit is accepted.
module uart_rx_stream #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int CLKS_PER_BIT     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  input  logic                        i_ready,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_is_valid,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        overrun_error
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                        break_detected
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(INPUT_DATA_WIDTH + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                        state_q, state_d;
  logic                          sync1_q, sync1_d;
  logic                          sync2_q, sync2_d;
  logic                          line_prev_q, line_prev_d;
  logic [CW-1:0]                 clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [INPUT_DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                          par_bad_q, par_bad_d;
  logic [INPUT_DATA_WIDTH-1:0]   data_q, data_d;
  logic                          dv_q, dv_d;
  logic                          perr_q, perr_d;
  logic                          ferr_q, ferr_d;
  logic                          oerr_q, oerr_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                          par_low_q, par_low_d;
  logic                          brk_wait_q, brk_wait_d;
  logic                          brk_q, brk_d;
  logic                          is_break;
`endif

  logic fall;
  logic bit_tick;
  logic half_tick;
  logic brk_hold;

  assign fall      = line_prev_q & ~sync2_q;
  assign bit_tick  = (clk_cnt_q == BIT_END);
  assign half_tick = (clk_cnt_q == HALF_END);

`ifdef UART_RX_BREAK_DETECT_EN
  // A break frame: every data bit, the parity bit (if any) and stop all low.
  assign brk_hold = brk_wait_q;
  assign is_break = ~sync2_q && (shift_q == '0) &&
                    ((PARITY_ENABLED == 0) || par_low_q);
`else
  assign brk_hold = 1'b0;
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      oerr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_low_q   <= 1'b0;
      brk_wait_q  <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      line_prev_q <= line_prev_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      oerr_q      <= oerr_d;
`ifdef UART_RX_BREAK_DETECT_EN
      par_low_q   <= par_low_d;
      brk_wait_q  <= brk_wait_d;
      brk_q       <= brk_d;
`endif
    end
  end

  // Next-state: walk the frame; START re-checks the line at mid-bit so a
  // short low glitch drops back to IDLE without any report.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fall && !brk_hold) state_d = S_START;
      S_START:  if (half_tick) state_d = sync2_q ? S_IDLE : S_DATA;
      S_DATA:   if (bit_tick && (bit_cnt_q == LAST_BIT))
                  state_d = (PARITY_ENABLED != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP:   if (bit_tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath/outputs: sampling counters, shift register, completion verdict.
  always_comb begin
    sync1_d     = serial_in;
    sync2_d     = sync1_q;
    line_prev_d = sync2_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    data_d      = data_q;
    dv_d        = dv_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    oerr_d      = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    par_low_d   = par_low_q;
    brk_wait_d  = brk_wait_q;
    brk_d       = 1'b0;
`endif

    // Consumer handshake; a same-cycle completion below overrides this.
    if (dv_q && i_ready) dv_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
        // After a break, require a full bit period of continuous high line.
        if (brk_wait_q && sync2_q) begin
          if (bit_tick) brk_wait_d = 1'b0;
          else          clk_cnt_d  = clk_cnt_q + 1'b1;
        end
        if (fall && !brk_hold) par_low_d = 1'b0;
`endif
        if (fall && !brk_hold) begin
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (half_tick) clk_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          shift_d   = {sync2_q, shift_q[INPUT_DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          par_bad_d = sync2_q ^ (^shift_q);
`ifdef UART_RX_BREAK_DETECT_EN
          par_low_d = ~sync2_q;
`endif
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          if (par_bad_q) perr_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
          if (is_break) begin
            brk_d      = 1'b1;
            brk_wait_d = 1'b1;
          end else if (!sync2_q) begin
            ferr_d = 1'b1;
          end
`else
          if (!sync2_q) ferr_d = 1'b1;
`endif
          if (sync2_q && !par_bad_q) begin
            if (!dv_q || i_ready) begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end else begin
              oerr_d = 1'b1;
            end
          end
        end
      end
      default: clk_cnt_d = '0;
    endcase
  end

  assign received_data = data_q;
  assign data_is_valid = dv_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun_error = oerr_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_detected = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: directed spec scenarios plus randomized frames
// checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_stream;
  localparam int W   = 8;
  localparam int PAR = 1;
  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         serial_in = 1'b1;
  logic         i_ready = 1'b1;
  logic [W-1:0] received_data;
  logic         data_is_valid, parity_error, framing_error, overrun_error;
`ifdef UART_RX_BREAK_DETECT_EN
  logic         break_detected;
`endif

  uart_rx_stream #(.INPUT_DATA_WIDTH(W), .PARITY_ENABLED(PAR), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .i_ready(i_ready),
    .received_data(received_data), .data_is_valid(data_is_valid),
    .parity_error(parity_error), .framing_error(framing_error),
    .overrun_error(overrun_error)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_detected(break_detected)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed activity, sampled on the falling edge.
  int perr_n = 0, ferr_n = 0, oerr_n = 0, brk_n = 0, width_viol = 0;
  logic [W-1:0] acc_q[$];
  logic pe_p = 1'b0, fe_p = 1'b0, oe_p = 1'b0, acc_p = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
  logic bk_p = 1'b0;
`endif

  always @(negedge clk) begin
    if (parity_error)  perr_n <= perr_n + 1;
    if (framing_error) ferr_n <= ferr_n + 1;
    if (overrun_error) oerr_n <= oerr_n + 1;
    if ((parity_error && pe_p) || (framing_error && fe_p) || (overrun_error && oe_p) ||
        (data_is_valid && acc_p))
      width_viol <= width_viol + 1;
`ifdef UART_RX_BREAK_DETECT_EN
    if (break_detected) brk_n <= brk_n + 1;
    bk_p <= break_detected;
`endif
    if (data_is_valid && i_ready) acc_q.push_back(received_data);
    pe_p  <= parity_error;
    fe_p  <= framing_error;
    oe_p  <= overrun_error;
    acc_p <= data_is_valid && i_ready;
  end

  // Reference model state (frame granularity).
  int exp_perr = 0, exp_ferr = 0, exp_oerr = 0, exp_brk = 0;
  logic [W-1:0] exp_q[$];
  logic         m_dv = 1'b0;
  logic [W-1:0] m_last = '0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_frame(input logic [W-1:0] d, input logic pb, input logic sb);
    logic pbad;
    pbad = (PAR != 0) && (pb != (^d));
    if (pbad) exp_perr++;
`ifdef UART_RX_BREAK_DETECT_EN
    if (!sb && d == '0 && (PAR == 0 || !pb)) exp_brk++;
    else if (!sb) exp_ferr++;
`else
    if (!sb) exp_ferr++;
`endif
    if (sb && !pbad) begin
      if (m_dv && !i_ready) exp_oerr++;
      else begin
        m_last = d;
        if (i_ready) exp_q.push_back(d);
        else m_dv = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pb, input logic sb);
    serial_in = 1'b0; tick(CPB);
    for (int i = 0; i < W; i++) begin serial_in = d[i]; tick(CPB); end
    if (PAR != 0) begin serial_in = pb; tick(CPB); end
    serial_in = sb; tick(CPB);
    serial_in = 1'b1;
    model_frame(d, pb, sb);
    if (!sb) tick(CPB);
    tick(2);
  endtask

  task automatic set_ready(input logic v);
    i_ready = v;
    if (v && m_dv) begin exp_q.push_back(m_last); m_dv = 1'b0; end
    tick(2);
  endtask

  task automatic test_reset;
    reset = 1'b0; serial_in = 1'b1; i_ready = 1'b1;
    tick(3);
    checks++; if (data_is_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_is_valid); end
    checks++; if (received_data !== '0) begin errors++; $display("FAIL reset_data got %h want 00", received_data); end
    checks++; if ({parity_error, framing_error, overrun_error} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {parity_error, framing_error, overrun_error}); end
    reset = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic test_directed;
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++; if (received_data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", received_data); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL a5_accepts got %0d want 1", acc_q.size()); end
    checks++; if ({perr_n, ferr_n, oerr_n} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL a5_errors got %0d/%0d/%0d want 0/0/0", perr_n, ferr_n, oerr_n); end
    send_frame(8'h3C, 1'b1, 1'b1);
    checks++; if (perr_n != exp_perr) begin errors++; $display("FAIL 3c_parity got %0d want %0d", perr_n, exp_perr); end
    send_frame(8'h5A, 1'b0, 1'b0);
    checks++; if (ferr_n != exp_ferr) begin errors++; $display("FAIL 5a_framing got %0d want %0d", ferr_n, exp_ferr); end
    checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL dir_accepts got %0d want %0d", acc_q.size(), exp_q.size()); end
    checks++; if (data_is_valid !== m_dv) begin errors++; $display("FAIL dir_valid got %b want %b", data_is_valid, m_dv); end
    checks++; if (width_viol != 0) begin errors++; $display("FAIL dir_pulse_width got %0d want 0", width_viol); end
    acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun;
    set_ready(1'b0);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    checks++; if (received_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h want 11", received_data); end
    checks++; if (data_is_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", data_is_valid); end
    checks++; if (oerr_n != exp_oerr) begin errors++; $display("FAIL ovr_pulses got %0d want %0d", oerr_n, exp_oerr); end
    set_ready(1'b1);
    tick(2);
    checks++; if (data_is_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", data_is_valid); end
    checks++; if (acc_q.size() != 1 || exp_q.size() != 1 || acc_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL ovr_accept got %0d entries want 1 entry of 11", acc_q.size()); end
    acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch;
    serial_in = 1'b0; tick(4);
    serial_in = 1'b1; tick(3 * CPB);
    checks++; if ({perr_n, ferr_n, oerr_n} !== {exp_perr, exp_ferr, exp_oerr}) begin
      errors++; $display("FAIL glitch_errors got %0d/%0d/%0d want %0d/%0d/%0d", perr_n, ferr_n, oerr_n, exp_perr, exp_ferr, exp_oerr); end
    checks++; if (acc_q.size() != 0 || received_data !== m_last) begin
      errors++; $display("FAIL glitch_output got %0d accepts data %h want 0 accepts data %h", acc_q.size(), received_data, m_last); end
    send_frame(8'h96, 1'b0, 1'b1);
    checks++; if (acc_q.size() != 1 || acc_q[0] !== 8'h96) begin
      errors++; $display("FAIL glitch_recover got %0d accepts want one 96", acc_q.size()); end
    acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    serial_in = 1'b0; tick(CPB);
    for (int i = 0; i < 3; i++) begin serial_in = 1'b1; tick(CPB); end
    tick(CPB / 2);
    reset = 1'b0; tick(2); reset = 1'b1;
    m_dv = 1'b0; m_last = '0;
    tick(4 * CPB);
    checks++; if (received_data !== '0 || acc_q.size() != 0) begin
      errors++; $display("FAIL rstmid_quiet got data %h accepts %0d want 00 and 0", received_data, acc_q.size()); end
    send_frame(8'h81, 1'b0, 1'b1);
    checks++; if (acc_q.size() != 1 || acc_q[0] !== 8'h81) begin
      errors++; $display("FAIL rstmid_81 got %0d accepts want one 81", acc_q.size()); end
    checks++; if ({perr_n, ferr_n, oerr_n} !== {exp_perr, exp_ferr, exp_oerr}) begin
      errors++; $display("FAIL rstmid_errors got %0d/%0d/%0d want %0d/%0d/%0d", perr_n, ferr_n, oerr_n, exp_perr, exp_ferr, exp_oerr); end
    acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [W-1:0] d;
    logic pb, sb;
    for (int n = 0; n < 40; n++) begin
      d  = W'($urandom);
      pb = (^d) ^ ($urandom_range(0, 5) == 0);
      sb = (d == '0) ? 1'b1 : ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) set_ready(1'($urandom_range(0, 1)));
      send_frame(d, pb, sb);
      tick($urandom_range(0, CPB));
    end
    checks++; if (received_data !== m_last || data_is_valid !== m_dv) begin
      errors++; $display("FAIL rnd_hold got %h/%b want %h/%b", received_data, data_is_valid, m_last, m_dv); end
    set_ready(1'b1);
    tick(2);
    checks++; if ({perr_n, ferr_n, oerr_n} !== {exp_perr, exp_ferr, exp_oerr}) begin
      errors++; $display("FAIL rnd_errors got %0d/%0d/%0d want %0d/%0d/%0d", perr_n, ferr_n, oerr_n, exp_perr, exp_ferr, exp_oerr); end
    checks++;
    if (acc_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_accept_count got %0d want %0d", acc_q.size(), exp_q.size());
    end else begin
      foreach (acc_q[i]) begin
        checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte%0d got %h want %h", i, acc_q[i], exp_q[i]); end
      end
    end
    checks++; if (width_viol != 0) begin errors++; $display("FAIL rnd_pulse_width got %0d want 0", width_viol); end
    acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d;
    for (int n = 0; n < 4; n++) begin
      d = W'($urandom);
      serial_in = 1'b0; tick(CPB);
      for (int i = 0; i < W; i++) begin serial_in = d[i]; tick(CPB); end
      serial_in = ^d; tick(CPB);
      serial_in = 1'b1; tick(CPB);
      model_frame(d, ^d, 1'b1);
    end
    tick(4);
    checks++;
    if (acc_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d want 4", acc_q.size());
    end else begin
      foreach (acc_q[i]) begin
        checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, acc_q[i], exp_q[i]); end
      end
    end
    acc_q.delete(); exp_q.delete();
  endtask

  task automatic test_break;
    serial_in = 1'b0; tick(12 * CPB);
    serial_in = 1'b1; tick(3 * CPB);
`ifdef UART_RX_BREAK_DETECT_EN
    exp_brk++;
    checks++; if (brk_n != exp_brk) begin errors++; $display("FAIL break_pulse got %0d want %0d", brk_n, exp_brk); end
`else
    exp_ferr++;
`endif
    checks++; if (ferr_n != exp_ferr) begin errors++; $display("FAIL break_framing got %0d want %0d", ferr_n, exp_ferr); end
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++; if (acc_q.size() != 1 || acc_q[0] !== 8'h5A) begin
      errors++; $display("FAIL break_recover got %0d accepts want one 5a", acc_q.size()); end
    acc_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_directed;
    test_overrun;
    test_glitch;
    test_reset_mid;
    test_random;
    test_back_to_back;
    test_break;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter PARITY_ENABLED, default 1; 1 inserts an even-parity bit after the data bits, 0 omits it.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period (even, >=4).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port serial_in  input  1  asynchronous UART line, idle high.
REQ-007 SHALL have port i_ready  input  1  consumer accepts received_data while data_is_valid is high.
REQ-008 SHALL have port received_data  output  INPUT_DATA_WIDTH  last decoded byte.
REQ-009 SHALL have port data_is_valid  output  1  received_data holds an unconsumed byte.
REQ-010 SHALL have port parity_error  output  1  one-cycle pulse: parity mismatch.
REQ-011 SHALL have port framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port overrun_error  output  1  one-cycle pulse: frame completed while data_is_valid high.

Function
REQ-013 serial_in SHALL pass a two-flop synchronizer; all decoding uses the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_ENABLED=0.
REQ-015 IDLE->START on a high-to-low transition of synchronized line; bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles, line low -> DATA, line high -> IDLE (glitch rejection, no error).
REQ-017 DATA: sample every CLKS_PER_BIT cycles from mid-start; bits LSB first; after INPUT_DATA_WIDTH samples -> PARITY or STOP.
REQ-018 PARITY: one sample; mismatch with XOR of data bits (even parity) sets a pending parity flag.
REQ-019 STOP: one sample, then return to IDLE in the next cycle; completion is evaluated at this sample.
REQ-020 At completion with stop high and no parity mismatch: if data_is_valid low, load received_data and set data_is_valid; if high, pulse overrun_error, drop the new byte, keep the old.
REQ-021 Stop low SHALL pulse framing_error and discard the byte; parity mismatch SHALL pulse parity_error and discard; both may pulse in the same cycle.
REQ-022 data_is_valid SHALL clear the cycle after data_is_valid&&i_ready; if acceptance and completion coincide, the new byte loads and data_is_valid stays high, no overrun.
REQ-023 Error pulses SHALL be exactly one clk wide; latency from stop-bit sample to data_is_valid or error SHALL be one cycle.
REQ-024 Reception SHALL not depend on i_ready; a new frame may be decoded while data_is_valid is high.

Reset
REQ-025 With reset low at a clk edge: FSM to IDLE, counters 0, synchronizer flops 1, received_data 0, all flags 0.
REQ-026 Reset mid-frame SHALL abandon the frame silently; after release, reception restarts only on a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_BREAK_DETECT_EN SHALL, when defined, add output break_detected (1 bit), a one-cycle pulse when a frame's data bits, parity bit (if present) and stop bit are all sampled low; the FSM then waits in IDLE for the line to be high for one full CLKS_PER_BIT before accepting a new start; framing_error is suppressed for that frame.
REQ-028 Without UART_RX_BREAK_DETECT_EN, port break_detected SHALL not exist and an all-zero frame SHALL be reported as framing_error only.

Verification
REQ-029 CLKS_PER_BIT=16, send 0xA5 with parity 0 and stop 1, i_ready=1 -> received_data=0xA5, data_is_valid high one cycle, no error pulses.
REQ-030 Send 0x3C with parity 1 -> parity_error pulses once, data_is_valid stays 0.
REQ-031 Send 0x5A with stop bit 0 -> framing_error pulses once, data_is_valid stays 0.
REQ-032 i_ready=0, send 0x11 then 0x22 -> received_data=0x11 held, overrun_error pulses at second completion.
REQ-033 Low glitch of 4 clk on idle line -> FSM returns to IDLE, no outputs change.
REQ-034 Assert reset during bit 3 of 0xFF, release, then send 0x81 -> only 0x81 reported; with UART_RX_BREAK_DETECT_EN, a 12-bit-long low line -> break_detected pulses, no framing_error.
